board_lock_clear: RTL and testbench

Playfield stage directly downstream of the falling-block decision logic.
- On a touchdown, writes the landed 4x4 shape into a 10-column x 20-row occupancy grid.
- Clears full rows with gravity shift, then updates Score.
- Pulses ResetShape to respawn the next block, and exposes a row read port to the renderer.

---
 rtl/board_lock_clear_if.sv | 26 ++
 rtl/board_lock_clear.sv | 169 ++++++++++++++++
 tb/tb_board_lock_clear.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/board_lock_clear_if.sv
// Playfield port bundle between block-decision logic/renderer and board_lock_clear.
// master drives piece, control and read-select; slave returns row data and status.
interface board_lock_clear_if;
    logic        reset_game;
    logic [1:0]  gamestate;
    logic        touchdown;
    logic [9:0]  Block_X_Pos;
    logic [9:0]  Block_Y_Pos;
    logic [15:0] shape_mask;
    logic [4:0]  rd_row;
    logic [9:0]  rd_bits;
    logic        ResetShape;
    logic [13:0] Score;
    logic        game_over;
    logic        busy;

    modport master (
        output reset_game, gamestate, touchdown, Block_X_Pos, Block_Y_Pos, shape_mask, rd_row,
        input  rd_bits, ResetShape, Score, game_over, busy
    );

    modport slave (
        input  reset_game, gamestate, touchdown, Block_X_Pos, Block_Y_Pos, shape_mask, rd_row,
        output rd_bits, ResetShape, Score, game_over, busy
    );
endinterface

// File: rtl/board_lock_clear.sv
// Locks a landed 4x4 shape into a 10x20 grid, clears full rows with gravity, scores, respawns.
// Latency: 4 lock cycles + one per checked row + r+1 per cleared row + 1 done; rd_bits combinational.
// No backpressure: touchdown edges outside IDLE are dropped. LINE_BONUS_EN selects bonus scoring.
module board_lock_clear #(
    parameter int X_MIN      = 250,
    parameter int Y_MIN      = 100,
    parameter int COLS       = 10,
    parameter int ROWS       = 20,
    parameter int CELL_SHIFT = 4
) (
    input  logic              decis_clk,
    input  logic              Reset,
    board_lock_clear_if.slave bus
);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [2:0] {S_IDLE, S_LOCK, S_CHECK, S_SHIFT, S_DONE, S_OVER} state_t;

    state_t           r_state, w_state_nxt;
    logic [COLS-1:0]  r_grid [ROWS];
    logic             r_td_q;
    logic [9:0]       r_base_col, r_base_row;
    logic [15:0]      r_mask;
    logic [1:0]       r_k;
    logic [RW-1:0]    r_r, r_p;
    logic [2:0]       r_lines;
    logic [13:0]      r_score;

    logic             w_td_edge, w_row_full, w_lock_row_ok;
    logic [9:0]       w_sub_x, w_sub_y;
    logic [10:0]      w_lock_row;
    logic [COLS-1:0]  w_lock_bits;
    logic [14:0]      w_score_sum;
    logic             w_reset_shape, w_busy, w_game_over;

    function automatic logic [13:0] points(input logic [2:0] n);
`ifdef LINE_BONUS_EN
        case (n)
            3'd0:    points = 14'd0;
            3'd1:    points = 14'd1;
            3'd2:    points = 14'd3;
            3'd3:    points = 14'd5;
            default: points = 14'd8;
        endcase
`else
        points = {11'd0, n};
`endif
    endfunction

    assign w_sub_x       = bus.Block_X_Pos - 10'(X_MIN);
    assign w_sub_y       = bus.Block_Y_Pos - 10'(Y_MIN);
    assign w_td_edge     = bus.touchdown & ~r_td_q & (bus.gamestate == 2'd2) & (r_state == S_IDLE);
    assign w_row_full    = &r_grid[r_r];
    assign w_lock_row    = {1'b0, r_base_row} + {9'd0, r_k};
    assign w_lock_row_ok = w_lock_row < 11'(ROWS);
    assign w_score_sum   = {1'b0, r_score} + {1'b0, points(r_lines)};

    // Shape row k spread onto grid columns; out-of-range columns (incl. wrapped bases) drop out.
    always_comb begin
        w_lock_bits = '0;
        for (int j = 0; j < COLS; j++) begin
            if (11'(j) >= {1'b0, r_base_col} && 11'(j) < {1'b0, r_base_col} + 11'd4)
                w_lock_bits[j] = r_mask[{r_k, 2'(11'(j) - {1'b0, r_base_col})}];
        end
    end

    always_ff @(posedge decis_clk or posedge Reset) begin
        if (Reset)                r_state <= S_IDLE;
        else if (bus.reset_game)  r_state <= S_IDLE;
        else                      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_reset_shape = 1'b0;
        w_busy        = 1'b1;
        w_game_over   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_td_edge) w_state_nxt = S_LOCK;
            end
            S_LOCK:  if (r_k == 2'd3) w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (w_row_full)      w_state_nxt = S_SHIFT;
                else if (r_r == '0)  w_state_nxt = S_DONE;
            end
            S_SHIFT: if (r_p == '0) w_state_nxt = S_CHECK;
            S_DONE: begin
                w_reset_shape = 1'b1;
                w_state_nxt   = (|r_grid[0]) ? S_OVER : S_IDLE;
            end
            S_OVER: begin
                w_busy      = 1'b0;
                w_game_over = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge decis_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < ROWS; i++) r_grid[i] <= '0;
            r_td_q     <= 1'b0;
            r_base_col <= '0;
            r_base_row <= '0;
            r_mask     <= '0;
            r_k        <= '0;
            r_r        <= '0;
            r_p        <= '0;
            r_lines    <= '0;
            r_score    <= '0;
        end else if (bus.reset_game) begin
            for (int i = 0; i < ROWS; i++) r_grid[i] <= '0;
            r_td_q     <= 1'b0;
            r_base_col <= '0;
            r_base_row <= '0;
            r_mask     <= '0;
            r_k        <= '0;
            r_r        <= '0;
            r_p        <= '0;
            r_lines    <= '0;
            r_score    <= '0;
        end else begin
            r_td_q <= bus.touchdown;
            case (r_state)
                S_IDLE: if (w_td_edge) begin
                    r_base_col <= w_sub_x >> CELL_SHIFT;
                    r_base_row <= w_sub_y >> CELL_SHIFT;
                    r_mask     <= bus.shape_mask;
                    r_k        <= '0;
                end
                S_LOCK: begin
                    if (w_lock_row_ok)
                        r_grid[w_lock_row[RW-1:0]] <= r_grid[w_lock_row[RW-1:0]] | w_lock_bits;
                    r_k <= r_k + 2'd1;
                    if (r_k == 2'd3) begin
                        r_r     <= RW'(ROWS - 1);
                        r_lines <= '0;
                    end
                end
                S_CHECK: begin
                    if (w_row_full) begin
                        r_p     <= r_r;
                        r_lines <= r_lines + 3'd1;
                    end else if (r_r != '0) begin
                        r_r <= r_r - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_p != '0) begin
                        r_grid[r_p] <= r_grid[r_p - 1'b1];
                        r_p         <= r_p - 1'b1;
                    end else begin
                        r_grid[0] <= '0;
                    end
                end
                S_DONE: r_score <= w_score_sum[14] ? 14'h3FFF : w_score_sum[13:0];
                default: ;
            endcase
        end
    end

    assign bus.rd_bits    = (int'(bus.rd_row) < ROWS) ? r_grid[RW'(bus.rd_row)] : '0;
    assign bus.ResetShape = w_reset_shape;
    assign bus.busy       = w_busy;
    assign bus.game_over  = w_game_over;
    assign bus.Score      = r_score;
endmodule

// File: tb/tb_board_lock_clear.sv
// Scoreboard bench for board_lock_clear: expected board/score pushed per lock, popped on ResetShape.
module tb_board_lock_clear;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   pulses = 0;

    typedef struct {
        logic [13:0] score;
        logic        over;
        logic [9:0]  r0, r17, r18, r19;
    } exp_t;
    exp_t sb[$];

    board_lock_clear_if bus();

    board_lock_clear dut (
        .decis_clk (clk),
        .Reset     (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.ResetShape) pulses <= pulses + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic get_row(input int r, output logic [9:0] v);
        bus.rd_row = 5'(r);
        #1;
        v = bus.rd_bits;
    endtask

    task automatic pulse_reset_game();
        @(negedge clk) bus.reset_game = 1'b1;
        @(negedge clk) bus.reset_game = 1'b0;
    endtask

    // Raw touchdown edge; cyc returns negedges until ResetShape (0 if never).
    task automatic drop_piece(input logic [9:0] x, input logic [9:0] y, input logic [15:0] m,
                              output int cyc);
        @(negedge clk);
        bus.Block_X_Pos = x;
        bus.Block_Y_Pos = y;
        bus.shape_mask  = m;
        bus.touchdown   = 1'b1;
        @(negedge clk);
        bus.touchdown = 1'b0;
        cyc = 1;
        while (!bus.ResetShape && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.ResetShape) cyc = 0;
    endtask

    task automatic lock_piece(input string tag, input logic [9:0] x, input logic [9:0] y,
                              input logic [15:0] m, input exp_t e, output int cyc);
        exp_t       got_e;
        logic [9:0] v;
        sb.push_back(e);
        drop_piece(x, y, m, cyc);
        got_e = sb.pop_front();
        if (cyc == 0) begin
            check({tag, "_pulse_timeout"}, 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            check({tag, "_score"}, 32'(bus.Score), 32'(got_e.score));
            check({tag, "_over"},  32'(bus.game_over), 32'(got_e.over));
            get_row(0,  v); check({tag, "_row0"},  32'(v), 32'(got_e.r0));
            get_row(17, v); check({tag, "_row17"}, 32'(v), 32'(got_e.r17));
            get_row(18, v); check({tag, "_row18"}, 32'(v), 32'(got_e.r18));
            get_row(19, v); check({tag, "_row19"}, 32'(v), 32'(got_e.r19));
        end
    endtask

    initial begin
        int         cyc;
        int         snap;
        logic [9:0] v;
        logic [13:0] two_line;
        exp_t       e;

        bus.reset_game  = 1'b0;
        bus.gamestate   = 2'd2;
        bus.touchdown   = 1'b0;
        bus.Block_X_Pos = '0;
        bus.Block_Y_Pos = '0;
        bus.shape_mask  = '0;
        bus.rd_row      = '0;
`ifdef LINE_BONUS_EN
        two_line = 14'd3;
`else
        two_line = 14'd2;
`endif

        #23 rst = 1'b0;
        @(negedge clk);
        check("rst_score", 32'(bus.Score), 0);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_over",  32'(bus.game_over), 0);
        check("rst_rs",    32'(bus.ResetShape), 0);
        get_row(19, v); check("rst_row19", 32'(v), 0);

        // single cell into row 19
        e = '{score: 14'd0, over: 1'b0, r0: 10'h000, r17: 10'h000, r18: 10'h000, r19: 10'h001};
        lock_piece("t1", 10'd250, 10'd404, 16'h0001, e, cyc);
        check("t1_latency", 32'(cyc), 32'd25);
        get_row(20, v); check("rd_oob20", 32'(v), 0);
        get_row(31, v); check("rd_oob31", 32'(v), 0);

        // touchdown edge while gamestate!=2 must not lock
        bus.gamestate = 2'd1;
        @(negedge clk) bus.touchdown = 1'b1;
        @(negedge clk) bus.touchdown = 1'b0;
        @(negedge clk);
        check("gs_busy", 32'(bus.busy), 0);
        bus.gamestate = 2'd2;

        // single full row clear
        pulse_reset_game();
        e = '{score: 14'd0, over: 1'b0, r0: 10'h000, r17: 10'h000, r18: 10'h000, r19: 10'h0F0};
        lock_piece("t2a", 10'd314, 10'd404, 16'h000F, e, cyc);
        e.r19 = 10'h3F0;
        lock_piece("t2b", 10'd378, 10'd404, 16'h0003, e, cyc);
        snap = pulses;
        e = '{score: 14'd1, over: 1'b0, r0: 10'h000, r17: 10'h000, r18: 10'h000, r19: 10'h000};
        lock_piece("t2c", 10'd250, 10'd404, 16'h000F, e, cyc);
        check("t2_pulses", 32'(pulses - snap), 1);

        // two-row clear with gravity
        pulse_reset_game();
        e = '{score: 14'd0, over: 1'b0, r0: 10'h000, r17: 10'h000, r18: 10'h03C, r19: 10'h03C};
        lock_piece("t3a", 10'd282, 10'd388, 16'h00FF, e, cyc);
        e.r18 = 10'h3FC; e.r19 = 10'h3FC;
        lock_piece("t3b", 10'd346, 10'd388, 16'h00FF, e, cyc);
        e.r17 = 10'h001;
        lock_piece("t3c", 10'd250, 10'd372, 16'h0001, e, cyc);
        e = '{score: two_line, over: 1'b0, r0: 10'h000, r17: 10'h000, r18: 10'h000, r19: 10'h001};
        lock_piece("t3d", 10'd250, 10'd388, 16'h0033, e, cyc);

        // level held high must lock exactly once
        snap = pulses;
        @(negedge clk);
        bus.Block_X_Pos = 10'd250;
        bus.Block_Y_Pos = 10'd404;
        bus.shape_mask  = 16'h0002;
        bus.touchdown   = 1'b1;
        repeat (1000) @(negedge clk);
        bus.touchdown = 1'b0;
        @(negedge clk);
        check("hold_pulses", 32'(pulses - snap), 1);
        get_row(19, v); check("hold_row19", 32'(v), 32'h003);
        check("hold_score", 32'(bus.Score), 32'(two_line));

        // top-out
        pulse_reset_game();
        e = '{score: 14'd0, over: 1'b1, r0: 10'h001, r17: 10'h000, r18: 10'h000, r19: 10'h000};
        lock_piece("t5", 10'd250, 10'd100, 16'h0001, e, cyc);
        snap = pulses;
        @(negedge clk);
        bus.Block_Y_Pos = 10'd404;
        bus.touchdown   = 1'b1;
        @(negedge clk) bus.touchdown = 1'b0;
        repeat (40) @(negedge clk);
        check("over_pulses", 32'(pulses - snap), 0);
        check("over_busy",   32'(bus.busy), 0);
        check("over_flag",   32'(bus.game_over), 1);
        get_row(19, v); check("over_row19", 32'(v), 0);

        // reset_game mid-SHIFT
        pulse_reset_game();
        check("rg_over", 32'(bus.game_over), 0);
        e = '{score: 14'd0, over: 1'b0, r0: 10'h000, r17: 10'h000, r18: 10'h000, r19: 10'h3F0};
        sb.push_back(e);
        drop_piece(10'd314, 10'd404, 16'h000F, cyc);
        lock_piece("t6b", 10'd378, 10'd404, 16'h0003, e, cyc);
        void'(sb.pop_front());
        snap = pulses;
        @(negedge clk);
        bus.Block_X_Pos = 10'd250;
        bus.shape_mask  = 16'h000F;
        bus.touchdown   = 1'b1;
        @(negedge clk) bus.touchdown = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy_before", 32'(bus.busy), 1);
        bus.reset_game = 1'b1;
        @(negedge clk);
        bus.reset_game = 1'b0;
        check("mid_score", 32'(bus.Score), 0);
        check("mid_busy",  32'(bus.busy), 0);
        check("mid_rs",    32'(bus.ResetShape), 0);
        for (int r = 0; r < 20; r++) begin
            get_row(r, v);
            check($sformatf("mid_row%0d", r), 32'(v), 0);
        end
        repeat (40) @(negedge clk);
        check("mid_pulses", 32'(pulses - snap), 0);

        // asynchronous Reset between clocks
        e = '{score: 14'd0, over: 1'b0, r0: 10'h000, r17: 10'h000, r18: 10'h000, r19: 10'h00F};
        lock_piece("t7a", 10'd250, 10'd404, 16'h000F, e, cyc);
        e.r19 = 10'h0FF;
        lock_piece("t7b", 10'd314, 10'd404, 16'h000F, e, cyc);
        e = '{score: 14'd1, over: 1'b0, r0: 10'h000, r17: 10'h000, r18: 10'h000, r19: 10'h000};
        lock_piece("t7c", 10'd378, 10'd404, 16'h0003, e, cyc);
        e = '{score: 14'd1, over: 1'b1, r0: 10'h001, r17: 10'h000, r18: 10'h000, r19: 10'h000};
        lock_piece("t7d", 10'd250, 10'd100, 16'h0001, e, cyc);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_score", 32'(bus.Score), 0);
        check("arst_over",  32'(bus.game_over), 0);
        check("arst_busy",  32'(bus.busy), 0);
        get_row(0, v); check("arst_row0", 32'(v), 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
